cp0_exc_ctrl: RTL
=================

Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller, sitting at the M stage.
- Consumes the per-stage exception code, branch-delay flag and victim PC that the pipeline registers carry forward.
- Produces the Req pulse that flushes every pipeline register and redirects fetch to the handler.
- Holds SR, Cause and EPC, services mfc0/mtc0 and supplies the return address for eret.

Parameters:
- EXC_ENTRY, 32'h0000_4180, handler entry address driven on handler_pc.
- PRID_VAL, 32'h2023_0007, constant value returned for register 15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  mtc0 write enable.
- cp0_addr  in  5  register index for read and write (12 SR, 13 Cause, 14 EPC, 15 PRId).
- cp0_in  in  32  mtc0 write data.
- cp0_out  out  32  mfc0 read data, combinational.
- vpc  in  32  PC of the victim instruction at the M stage.
- bd_in  in  1  victim is in a branch delay slot.
- exc_code_in  in  5  victim exception code; 0 = none.
- eret  in  1  eret at the M stage.
- hw_int  in  6  external interrupt lines, level-sensitive.
- req  out  1  take exception/interrupt this cycle, combinational.
- epc_out  out  32  eret target.
- handler_pc  out  32  constant EXC_ENTRY.

Behaviour:
- Reset, asynchronous: SR, Cause and EPC clear to 0. While reset is high, req = 0.
- SR fields:
  - IM = SR[15:10], R/W.
  - EXL = SR[1], R/W.
  - IE = SR[0], R/W.
  - All other bits read 0.
- Cause fields, read-only to mtc0:
  - BD = Cause[31].
  - IP = Cause[15:10].
  - ExcCode = Cause[6:2].
  - All other bits read 0.
- EPC: bits [31:2] are stored; bits [1:0] always read 0.
- IP update: Cause.IP <= hw_int on every clock edge, unconditionally.
- Request logic, combinational:
  - int_req = |(hw_int & IM) & IE & ~EXL. Uses live hw_int, not the latched IP.
  - exc_req = (exc_code_in != 0) & ~EXL.
  - req = int_req | exc_req.
  - Interrupt has priority over exception.
- On a clock edge with req = 1:
  - EXL <= 1.
  - BD <= bd_in.
  - ExcCode <= int_req ? 0 : exc_code_in.
  - EPC <= bd_in ? vpc - 4 : vpc, with bits [1:0] cleared.
- On a clock edge with eret = 1 and req = 0: EXL <= 0. No other register changes.
- mtc0, on a clock edge with en = 1 and req = 0:
  - Address 12 writes IM, EXL and IE.
  - Address 14 writes EPC[31:2].
  - Any other address: no effect.
- Simultaneous events:
  - req beats en: the write is dropped.
  - req beats eret.
  - en together with eret: the mtc0 write happens, and EXL still clears unless address 12 is written, in which case the written value wins.
- Read: cp0_out follows cp0_addr combinationally. Unimplemented addresses return 0. Reads return register state, with no write-through.
- epc_out:
  - Normally equals EPC.
  - If en = 1 and cp0_addr = 14 in the same cycle, epc_out = {cp0_in[31:2], 2'b00} (forwarding for eret immediately after mtc0).
- Nested exceptions: blocked by EXL. Exception codes arriving while EXL = 1 are ignored, and EPC is preserved.
- No latency beyond the single registered update. req asserts in the same cycle the victim appears.

Optional Feature:
- Macro CP0_TIMER_EN.
- When defined:
  - Count (address 9) increments every cycle, wrapping at 2^32.
  - Compare (address 11) is R/W.
  - Count is R/W by mtc0; a written value takes effect that edge, without incrementing.
  - Count == Compare sets a sticky timer_pending bit, which feeds IP[7] (Cause[15]) in place of hw_int[5].
  - An mtc0 write to Compare clears timer_pending.
  - Count and Compare reset to 0; timer_pending resets to 0. The compare only fires after reset once Count != 0 has been seen.
- When undefined: addresses 9 and 11 read 0, writes are ignored, and IP[7] = hw_int[5].

Test Plan:
1. Reset mid-run: set SR = 32'h0000_fc01, then pulse reset asynchronously between edges → cp0_out for addresses 12, 13 and 14 reads 0 immediately, and req = 0.
2. Exception not in a delay slot: exc_code_in = 5'd10, vpc = 32'h0000_3008, bd_in = 0 → req = 1 that cycle; after the edge, EPC = 32'h0000_3008, Cause = 32'h0000_0028 and EXL = 1. A repeated exc_code_in = 5'd4 then gives req = 0.
3. Exception in a delay slot: bd_in = 1, vpc = 32'h0000_3010, exc_code_in = 5'd12 → EPC = 32'h0000_300c and Cause[31] = 1.
4. Interrupt priority: SR = 32'h0000_0401, hw_int = 6'b000001 and exc_code_in = 5'd4 together → ExcCode = 0. Then eret → EXL = 0, and epc_out equals the stored EPC.
5. Forwarding and collision: mtc0 with en = 1, cp0_addr = 14, cp0_in = 32'h0000_3044 → epc_out = 32'h0000_3044 in the same cycle. mtc0 to address 12 while req = 1 → SR is unchanged.
6. Timer (CP0_TIMER_EN defined): Compare = 5, SR = 32'h0000_8001 → req = 1 on the cycle after Count reaches 5. Writing Compare then clears IP[7].

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller at the M stage: SR/Cause/EPC, mfc0/mtc0, eret target.
// Optional Count/Compare timer behind the CP0_TIMER_EN macro; req is combinational, state updates in one edge.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL  = 32'h2023_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [29:0] epc_q, epc_d;

    logic [5:0]  int_lines;
    logic        int_req;
    logic        exc_req;
    logic        wr_ok;
    logic [31:0] victim_pc;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_pending_q, timer_pending_d;
    logic        armed_q, armed_d;
    logic        timer_hit;

    // Timer replaces the top interrupt line.
    assign int_lines = {timer_pending_q, hw_int[4:0]};
`else
    assign int_lines = hw_int;
`endif

    always_comb begin
        int_req = (|(int_lines & im_q)) & ie_q & ~exl_q;
        exc_req = (exc_code_in != 5'd0) & ~exl_q;
        req     = (int_req | exc_req) & ~reset;
        wr_ok   = en & ~req;
    end

    assign victim_pc  = bd_in ? (vpc - 32'd4) : vpc;
    assign handler_pc = EXC_ENTRY;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = int_lines;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (req) begin
            exl_d      = 1'b1;
            bd_d       = bd_in;
            exc_code_d = int_req ? 5'd0 : exc_code_in;
            epc_d      = victim_pc[31:2];
        end else begin
            if (eret) begin
                exl_d = 1'b0;
            end
            // An SR write in the same cycle as eret overrides the EXL clear.
            if (en) begin
                case (cp0_addr)
                    ADDR_SR: begin
                        im_d  = cp0_in[15:10];
                        exl_d = cp0_in[1];
                        ie_d  = cp0_in[0];
                    end
                    ADDR_EPC: epc_d = cp0_in[31:2];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 30'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

`ifdef CP0_TIMER_EN
    // Count==Compare==0 straight out of reset must not fire.
    assign timer_hit = (count_q == compare_q) & (armed_q | (count_q != 32'd0));

    always_comb begin
        count_d         = count_q + 32'd1;
        compare_d       = compare_q;
        armed_d         = armed_q | (count_q != 32'd0);
        timer_pending_d = timer_pending_q | timer_hit;
        if (wr_ok && (cp0_addr == ADDR_COUNT)) begin
            count_d = cp0_in;
        end
        if (wr_ok && (cp0_addr == ADDR_COMPARE)) begin
            compare_d       = cp0_in;
            timer_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q         <= 32'd0;
            compare_q       <= 32'd0;
            timer_pending_q <= 1'b0;
            armed_q         <= 1'b0;
        end else begin
            count_q         <= count_d;
            compare_q       <= compare_d;
            timer_pending_q <= timer_pending_d;
            armed_q         <= armed_d;
        end
    end
`endif

    always_comb begin
        cp0_out = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_out = {16'd0, im_q, 8'd0, exl_q, ie_q};
            ADDR_CAUSE: cp0_out = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            ADDR_EPC:   cp0_out = {epc_q, 2'b00};
            ADDR_PRID:  cp0_out = PRID_VAL;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   cp0_out = count_q;
            ADDR_COMPARE: cp0_out = compare_q;
`endif
            default:    cp0_out = 32'd0;
        endcase
    end

    // Forward a same-cycle EPC write so an eret right behind the mtc0 sees it.
    always_comb begin
        epc_out = {epc_q, 2'b00};
        if (en && (cp0_addr == ADDR_EPC)) begin
            epc_out = {cp0_in[31:2], 2'b00};
        end
    end

endmodule
